// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// A grant lasts for up to BURST_LEN accepted beats. Each new grant costs one
// IDLE arbitration cycle. A full FIFO stalls the burst without using up beats.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    wdata,
    output logic [NUM_REQ-1:0]           ack,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [DATA_W-1:0]            fifo_wdata,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   gnt_id
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ID_W-1:0]   gnt_q, gnt_d;

    logic [ID_W-1:0]   rr_winner;
    logic              rr_found;
    logic [DATA_W-1:0] owner_data;

    // Round-robin scan: first requester after the last owner, wrapping at NUM_REQ
    always_comb begin
        int unsigned idx;
        rr_winner = gnt_q;
        rr_found  = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(gnt_q) + k) % NUM_REQ;
            if (!rr_found && req[ID_W'(idx)]) begin
                rr_winner = ID_W'(idx);
                rr_found  = 1'b1;
            end
        end
    end

    // State, beat counter and grant pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            gnt_q      <= LAST_ID;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            gnt_q      <= gnt_d;
        end
    end

    // Next-state logic: grant in IDLE, count/stall/release in BURST
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        gnt_d      = gnt_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    gnt_d      = rr_winner;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (fifo_wr_en) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else if (!req[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Owner's data slice and per-producer ack decode
    always_comb begin
        owner_data = '0;
        ack        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_q == ID_W'(i)) begin
                owner_data = wdata[i*DATA_W +: DATA_W];
                ack[i]     = fifo_wr_en;
            end
        end
    end

    assign fifo_wr_en = (state_q == BURST) && req[gnt_q] && !fifo_full;
    assign fifo_wdata = (state_q == BURST) ? owner_data : '0;
    assign busy       = (state_q == BURST);
    assign gnt_id     = gnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int L     = 4;
    localparam int IDW   = 2;
    localparam int BOUND = (N - 1) * (L + 1) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      ack;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wdata;
    logic              busy;
    logic [IDW-1:0]    gnt_id;

    logic [DW-1:0]     pdata [N];

    int total = 0;
    int bad   = 0;

    // Model of the arbiter: whether a grant is held, who holds it, beats so far
    bit m_busy  = 1'b0;
    int m_owner = N - 1;
    int m_cnt   = 0;

    logic [N-1:0] ack_seen = '0;
    int           wait_c  [N];
    int           stall_c [N];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) wdata[i*DW +: DW] = pdata[i];
    end

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .BURST_LEN (L)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .wdata      (wdata),
        .ack        (ack),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .gnt_id     (gnt_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cyc();
        reset = 1'b1;
        req   = '0;
        fifo_full = 1'b0;
        at_neg();
        next_cyc();
        reset = 1'b0;
    endtask

    // Every-cycle compare against the model, plus scoreboard and starvation tracking
    always @(negedge clk) begin : cmp
        logic          exp_wr;
        logic [N-1:0]  exp_ack;
        logic [DW-1:0] exp_wd;
        bit            found;
        if (reset) begin
            m_busy  = 1'b0;
            m_owner = N - 1;
            m_cnt   = 0;
            chk("rst_wr_en", 32'(fifo_wr_en), 0);
            chk("rst_ack", 32'(ack), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_wdata", 32'(fifo_wdata), 0);
            chk("rst_gnt_id", 32'(gnt_id), N - 1);
            for (int i = 0; i < N; i++) begin
                wait_c[i]  = 0;
                stall_c[i] = 0;
            end
            ack_seen = '0;
        end else begin
            exp_wr  = m_busy && req[m_owner] && !fifo_full;
            exp_ack = '0;
            if (exp_wr) exp_ack[m_owner] = 1'b1;
            exp_wd  = m_busy ? pdata[m_owner] : '0;
            chk("model_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
            chk("model_ack", 32'(ack), 32'(exp_ack));
            chk("model_wdata", 32'(fifo_wdata), 32'(exp_wd));
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_gnt_id", 32'(gnt_id), 32'(m_owner));
            chk("write_while_full", 32'(fifo_wr_en & fifo_full), 0);

            if (fifo_wr_en) got_q.push_back(fifo_wdata);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    exp_q.push_back(pdata[i]);
                    chk("starve_bound", (wait_c[i] <= BOUND + stall_c[i]) ? 1 : 0, 1);
                end
                if (ack[i] || !req[i]) begin
                    wait_c[i]  = 0;
                    stall_c[i] = 0;
                end else begin
                    wait_c[i]++;
                    if (fifo_full) stall_c[i]++;
                end
            end
            ack_seen = ack;

            // Advance the model to the state after the coming clock edge
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_owner + k) % N;
                    if (!found && req[j]) begin
                        found   = 1'b1;
                        m_owner = j;
                        m_busy  = 1'b1;
                        m_cnt   = 0;
                    end
                end
            end else if (exp_wr) begin
                m_cnt++;
                if (m_cnt == L) m_busy = 1'b0;
            end else if (!req[m_owner]) begin
                m_busy = 1'b0;
            end
        end
    end

    int rot_seq [22] = '{-1, 0, 0, 0, 0, -1, 1, 1, 1, 1, -1,
                         2, 2, 2, 2, -1, 3, 3, 3, 3, -1, 0};

    initial begin
        logic [N-1:0] exp_rot;
        reset     = 1'b1;
        req       = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) pdata[i] = '0;

        at_neg();
        chk("reset_gnt_literal", 32'(gnt_id), 3);
        next_cyc();
        reset = 1'b0;

        // Single producer 2: bubble, then A, B, C, then release
        req[2]   = 1'b1;
        pdata[2] = 4'hA;
        at_neg();
        chk("T2_bubble_busy", 32'(busy), 0);
        chk("T2_bubble_wr", 32'(fifo_wr_en), 0);
        next_cyc();
        at_neg();
        chk("T2_beatA_ack", 32'(ack), 32'h4);
        chk("T2_beatA_data", 32'(fifo_wdata), 32'hA);
        next_cyc();
        pdata[2] = 4'hB;
        at_neg();
        chk("T2_beatB_ack", 32'(ack), 32'h4);
        chk("T2_beatB_data", 32'(fifo_wdata), 32'hB);
        next_cyc();
        pdata[2] = 4'hC;
        at_neg();
        chk("T2_beatC_ack", 32'(ack), 32'h4);
        chk("T2_beatC_data", 32'(fifo_wdata), 32'hC);
        next_cyc();
        req[2] = 1'b0;
        at_neg();
        chk("T2_release_wr", 32'(fifo_wr_en), 0);
        chk("T2_release_busy", 32'(busy), 1);
        next_cyc();
        at_neg();
        chk("T2_idle_busy", 32'(busy), 0);

        // Rotation with every producer requesting
        do_reset();
        req = '1;
        for (int i = 0; i < N; i++) pdata[i] = DW'(i + 5);
        for (int c = 0; c < 22; c++) begin
            at_neg();
            exp_rot = '0;
            if (rot_seq[c] >= 0) exp_rot[rot_seq[c]] = 1'b1;
            chk("T3_rotation_ack", 32'(ack), 32'(exp_rot));
            next_cyc();
        end

        // Full stall after the first beat does not consume the burst
        do_reset();
        req[0]   = 1'b1;
        pdata[0] = 4'h1;
        at_neg();
        chk("T4_bubble_busy", 32'(busy), 0);
        next_cyc();
        at_neg();
        chk("T4_beat1_ack", 32'(ack), 32'h1);
        next_cyc();
        pdata[0]  = 4'h2;
        fifo_full = 1'b1;
        at_neg();
        chk("T4_stall1_wr", 32'(fifo_wr_en), 0);
        chk("T4_stall1_busy", 32'(busy), 1);
        next_cyc();
        at_neg();
        chk("T4_stall2_ack", 32'(ack), 0);
        next_cyc();
        fifo_full = 1'b0;
        at_neg();
        chk("T4_beat2_data", 32'(fifo_wdata), 32'h2);
        next_cyc();
        pdata[0] = 4'h3;
        at_neg();
        chk("T4_beat3_ack", 32'(ack), 32'h1);
        next_cyc();
        pdata[0] = 4'h4;
        at_neg();
        chk("T4_beat4_data", 32'(fifo_wdata), 32'h4);
        next_cyc();
        pdata[0] = 4'h5;
        at_neg();
        chk("T4_end_busy", 32'(busy), 0);
        chk("T4_end_wr", 32'(fifo_wr_en), 0);
        next_cyc();
        at_neg();
        chk("T4_regrant_ack", 32'(ack), 32'h1);

        // Owner 1 releases after one beat; producer 2 idle, 3 is next
        do_reset();
        req      = 4'b1010;
        pdata[1] = 4'h7;
        pdata[3] = 4'h9;
        at_neg();
        chk("T5_bubble_busy", 32'(busy), 0);
        next_cyc();
        at_neg();
        chk("T5_beat_ack", 32'(ack), 32'h2);
        next_cyc();
        req[1] = 1'b0;
        at_neg();
        chk("T5_release_wr", 32'(fifo_wr_en), 0);
        next_cyc();
        at_neg();
        chk("T5_idle_busy", 32'(busy), 0);
        chk("T5_idle_gnt", 32'(gnt_id), 1);
        next_cyc();
        at_neg();
        chk("T5_grant3_ack", 32'(ack), 32'h8);
        chk("T5_grant3_gnt", 32'(gnt_id), 3);
        chk("T5_grant3_data", 32'(fifo_wdata), 32'h9);

        // Reset asserted mid-burst acts immediately
        next_cyc();
        reset = 1'b1;
        #1;
        chk("T1_async_wr", 32'(fifo_wr_en), 0);
        chk("T1_async_ack", 32'(ack), 0);
        chk("T1_async_busy", 32'(busy), 0);
        at_neg();
        next_cyc();
        reset = 1'b0;
        req   = '1;
        at_neg();
        chk("T1_post_bubble", 32'(busy), 0);
        next_cyc();
        at_neg();
        chk("T1_first_grant", 32'(ack), 32'h1);

        // Randomized traffic
        for (int cyc = 0; cyc < 10000; cyc++) begin
            next_cyc();
            for (int i = 0; i < N; i++) begin
                if (ack_seen[i]) begin
                    if ($urandom_range(0, 9) < 7) begin
                        pdata[i] = DW'($urandom);
                        req[i]   = 1'b1;
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (!req[i]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        req[i]   = 1'b1;
                        pdata[i] = DW'($urandom);
                    end
                end else if (!(m_busy && m_owner == i) && $urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
            end
            fifo_full = ($urandom_range(0, 4) == 0);
        end
        next_cyc();
        req       = '0;
        fifo_full = 1'b0;
        repeat (3) next_cyc();

        chk("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk("sb_order", 32'(got_q[i]), 32'(exp_q[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
